// File: rtl/alu_issue_unit.sv
// alu_issue_unit
// Sequencer feeding an RV64I combinational ALU. Takes one OP / OP-IMM
// instruction at a time, reads its operands from a 32 x XLEN register file,
// presents them to the ALU, then writes the ALU result back to rd.
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   in_valid/in_ready        instruction handshake, in_instr = 32-bit word
//   alu_a/alu_b              operands (rs1, rs2 or sign-extended immediate)
//   alu_funct3/alu_funct7    function select for the ALU
//   alu_result/alu_zero      combinational ALU response
//   done_valid/rd/data/zero  one-cycle write-back report
//   illegal                  one-cycle pulse for a rejected instruction
//   dbg_addr/dbg_data        combinational register file peek (x0 reads 0)
module alu_issue_unit #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [2:0]      alu_funct3,
    output logic [6:0]      alu_funct7,
    input  logic [XLEN-1:0] alu_result,
    input  logic            alu_zero,
    output logic            done_valid,
    output logic [4:0]      done_rd,
    output logic [XLEN-1:0] done_data,
    output logic            done_zero,
    output logic            illegal,
    input  logic [4:0]      dbg_addr,
    output logic [XLEN-1:0] dbg_data
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DECODE = 2'd1;
    localparam logic [1:0] EXEC   = 2'd2;
    localparam logic [1:0] WB     = 2'd3;

    logic [1:0]      state;
    logic [31:0]     instr;
    logic [XLEN-1:0] regs [32];

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [5:0]      imm_top;
    logic            is_op;
    logic            is_op_imm;
    logic            is_shift_imm;
    logic            legal;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] next_b;
    logic [6:0]      next_f7;

    assign opcode       = instr[6:0];
    assign funct3       = instr[14:12];
    assign rd           = instr[11:7];
    assign rs1          = instr[19:15];
    assign rs2          = instr[24:20];
    assign imm_top      = instr[31:26];
    assign is_op        = (opcode == 7'b0110011);
    assign is_op_imm    = (opcode == 7'b0010011);
    assign is_shift_imm = is_op_imm && (funct3 == 3'b001 || funct3 == 3'b101);

    assign rs1_val  = (rs1 == 5'd0) ? '0 : regs[rs1];
    assign rs2_val  = (rs2 == 5'd0) ? '0 : regs[rs2];
    assign dbg_data = (dbg_addr == 5'd0) ? '0 : regs[dbg_addr];

    // Masking with rst keeps in_ready low during the reset cycle even
    // before the state register has been forced to IDLE.
    assign in_ready = (state == IDLE) && !rst;

    // Legality: OP allows only the base and SUB/SRA funct7 patterns;
    // OP-IMM shifts must carry a clean upper immediate (SRAI may set bit 30).
    always_comb begin
        legal = 1'b0;
        if (is_op) begin
            legal = (instr[31:25] == 7'b0000000) ||
                    (instr[31:25] == 7'b0100000 &&
                     (funct3 == 3'b000 || funct3 == 3'b101));
        end else if (is_op_imm) begin
            case (funct3)
                3'b001:  legal = (imm_top == 6'b000000);
                3'b101:  legal = (imm_top == 6'b000000) || (imm_top == 6'b010000);
                default: legal = 1'b1;
            endcase
        end
    end

    // Non-shift OP-IMM forces funct7 to zero so the ALU never sees ADDI
    // with immediate bit 30 set as a subtract.
    assign next_b  = is_op ? rs2_val : {{(XLEN-12){instr[31]}}, instr[31:20]};
    assign next_f7 = is_op ? instr[31:25] :
                     (is_shift_imm ? {imm_top, 1'b0} : 7'b0000000);

    // Main sequencer: IDLE -> DECODE -> EXEC -> WB, or DECODE -> IDLE when
    // the instruction is rejected. Reset wins in every state and drops any
    // write that was about to happen.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            instr      <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_funct3 <= '0;
            alu_funct7 <= '0;
            done_valid <= 1'b0;
            done_rd    <= '0;
            done_data  <= '0;
            done_zero  <= 1'b0;
            illegal    <= 1'b0;
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else begin
            illegal    <= 1'b0;
            done_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        instr <= in_instr;
                        state <= DECODE;
                    end
                end
                DECODE: begin
                    if (legal) begin
                        alu_a      <= rs1_val;
                        alu_b      <= next_b;
                        alu_funct3 <= funct3;
                        alu_funct7 <= next_f7;
                        state      <= EXEC;
                    end else begin
                        illegal <= 1'b1;
                        state   <= IDLE;
                    end
                end
                EXEC: begin
                    if (rd != 5'd0) begin
                        regs[rd] <= alu_result;
                    end
                    done_rd    <= rd;
                    done_data  <= (rd == 5'd0) ? '0 : alu_result;
                    done_zero  <= alu_zero;
                    done_valid <= 1'b1;
                    state      <= WB;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_unit.sv
// tb_alu_issue_unit
// Self-checking bench for alu_issue_unit. Supplies a behavioural RV64I ALU,
// runs a table of directed instructions with known results, a reset-in-EXEC
// sequence, and a batch of random instructions checked against an
// instruction-level reference model with its own register array.
module tb_alu_issue_unit;

    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [2:0]      alu_funct3;
    logic [6:0]      alu_funct7;
    logic [XLEN-1:0] alu_result;
    logic            alu_zero;
    logic            done_valid;
    logic [4:0]      done_rd;
    logic [XLEN-1:0] done_data;
    logic            done_zero;
    logic            illegal;
    logic [4:0]      dbg_addr;
    logic [XLEN-1:0] dbg_data;

    int pass_count  = 0;
    int check_count = 0;

    logic [63:0] ref_regs [32];

    typedef struct {
        logic [31:0] instr;
        logic        legal;
        logic [4:0]  rd;
        logic [63:0] data;
    } vec_t;

    vec_t vecs [8];

    always #5 clk = ~clk;

    alu_issue_unit #(.XLEN(XLEN)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_funct3 (alu_funct3),
        .alu_funct7 (alu_funct7),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .done_valid (done_valid),
        .done_rd    (done_rd),
        .done_data  (done_data),
        .done_zero  (done_zero),
        .illegal    (illegal),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    // RV64I integer operation; alt selects SUB / SRA.
    function automatic logic [63:0] rv_alu(logic [2:0] f3, logic alt,
                                           logic [63:0] a, logic [63:0] b);
        case (f3)
            3'd0:    return alt ? a - b : a + b;
            3'd1:    return a << b[5:0];
            3'd2:    return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
            3'd3:    return (a < b) ? 64'd1 : 64'd0;
            3'd4:    return a ^ b;
            3'd5:    return alt ? 64'($signed(a) >>> b[5:0]) : a >> b[5:0];
            3'd6:    return a | b;
            default: return a & b;
        endcase
    endfunction

    // Behavioural ALU the unit drives.
    always_comb begin
        alu_result = rv_alu(alu_funct3, alu_funct7[5], alu_a, alu_b);
        alu_zero   = (alu_result == 64'd0);
    end

    // Instruction-level reference: what the instruction means, given the
    // architectural register state held in ref_regs.
    function automatic void model(input logic [31:0] ins, output logic legal,
                                  output logic [63:0] a, output logic [63:0] b,
                                  output logic [6:0] f7, output logic [63:0] res);
        logic [6:0] op;
        logic [2:0] f3;
        logic [5:0] top6;
        op    = ins[6:0];
        f3    = ins[14:12];
        top6  = ins[31:26];
        a     = ref_regs[ins[19:15]];
        legal = 1'b0;
        b     = 64'd0;
        f7    = 7'd0;
        if (op == 7'h33) begin
            b     = ref_regs[ins[24:20]];
            f7    = ins[31:25];
            legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
        end else if (op == 7'h13) begin
            b = {{52{ins[31]}}, ins[31:20]};
            if (f3 == 3'd1) begin
                legal = (top6 == 6'h00);
                f7    = {top6, 1'b0};
            end else if (f3 == 3'd5) begin
                legal = (top6 == 6'h00) || (top6 == 6'h10);
                f7    = {top6, 1'b0};
            end else begin
                legal = 1'b1;
            end
        end
        res = rv_alu(f3, f7[5], a, b);
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        check_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic check_reg(input string name, input logic [4:0] r);
        dbg_addr = r;
        #1;
        checkOutput(name, dbg_data, ref_regs[r]);
    endtask

    task automatic check_all_regs(input string name);
        for (int r = 0; r < 32; r++) begin
            check_reg(name, 5'(r));
        end
    endtask

    // Issues one instruction at a negedge and follows it cycle by cycle.
    // While the unit is busy a decoy ADDI x31 is offered and must be ignored.
    task automatic applyStimulus(input logic [31:0] ins, input logic has_exp,
                                 input logic exp_legal, input logic [4:0] exp_rd,
                                 input logic [63:0] exp_data);
        logic        legal;
        logic [63:0] a;
        logic [63:0] b;
        logic [6:0]  f7;
        logic [63:0] res;
        logic [4:0]  rd;
        int          waited;
        waited = 0;
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("ready_before_issue", in_ready, 1);
        model(ins, legal, a, b, f7, res);
        rd       = ins[11:7];
        in_valid = 1'b1;
        in_instr = ins;
        @(posedge clk);
        @(negedge clk);
        checkOutput("decode_in_ready", in_ready, 0);
        checkOutput("decode_done_valid", done_valid, 0);
        checkOutput("decode_illegal", illegal, 0);
        in_instr = 32'h12300F93;
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("illegal_flag", illegal, !legal);
        if (has_exp) checkOutput("table_illegal_flag", illegal, !exp_legal);
        if (!legal) begin
            checkOutput("illegal_in_ready", in_ready, 1);
            checkOutput("illegal_done_valid", done_valid, 0);
            @(negedge clk);
            checkOutput("illegal_pulse_end", illegal, 0);
            checkOutput("illegal_no_done", done_valid, 0);
            check_reg("illegal_no_write", rd);
        end else begin
            checkOutput("exec_in_ready", in_ready, 0);
            checkOutput("alu_a", alu_a, a);
            checkOutput("alu_b", alu_b, b);
            checkOutput("alu_funct3", alu_funct3, ins[14:12]);
            checkOutput("alu_funct7", alu_funct7, f7);
            @(negedge clk);
            checkOutput("wb_done_valid", done_valid, 1);
            checkOutput("wb_done_rd", done_rd, rd);
            checkOutput("wb_done_data", done_data, (rd == 5'd0) ? 64'd0 : res);
            checkOutput("wb_done_zero", done_zero, res == 64'd0);
            checkOutput("wb_in_ready", in_ready, 0);
            if (has_exp) begin
                checkOutput("table_done_rd", done_rd, exp_rd);
                checkOutput("table_done_data", done_data, exp_data);
            end
            if (rd != 5'd0) ref_regs[rd] = res;
            @(negedge clk);
            checkOutput("post_done_valid", done_valid, 0);
            checkOutput("post_in_ready", in_ready, 1);
            check_reg("post_regfile", rd);
            if (has_exp) begin
                dbg_addr = exp_rd;
                #1;
                checkOutput("table_regfile", dbg_data, exp_data);
            end
        end
    endtask

    function automatic logic [31:0] random_instr();
        logic [31:0] r;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [11:0] imm;
        logic [6:0]  op;
        int          k;
        r   = $urandom;
        rd  = r[4:0];
        rs1 = r[9:5];
        rs2 = r[14:10];
        f3  = r[17:15];
        k   = $urandom_range(0, 9);
        case ($urandom_range(0, 2))
            0:       f7 = 7'h00;
            1:       f7 = 7'h20;
            default: f7 = 7'($urandom);
        endcase
        imm = 12'($urandom);
        if (k <= 3) begin
            return {f7, rs2, rs1, f3, rd, 7'h33};
        end else if (k <= 7) begin
            if (f3 == 3'd1 || f3 == 3'd5) begin
                case ($urandom_range(0, 3))
                    0, 1:    imm[11:6] = 6'h00;
                    2:       imm[11:6] = 6'h10;
                    default: imm[11:6] = 6'($urandom);
                endcase
            end
            return {imm, rs1, f3, rd, 7'h13};
        end else if (k == 8) begin
            op = 7'($urandom);
            if (op == 7'h33 || op == 7'h13) op = 7'h6F;
            return {r[31:7], op};
        end else begin
            return {7'($urandom), rs2, rs1, f3, rd, 7'h33};
        end
    endfunction

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{32'hFFF00093, 1'b1, 5'd1, 64'hFFFFFFFFFFFFFFFF};
        vecs[1] = '{32'h4040D113, 1'b1, 5'd2, 64'hFFFFFFFFFFFFFFFF};
        vecs[2] = '{32'h03C0D193, 1'b1, 5'd3, 64'h000000000000000F};
        vecs[3] = '{32'h40118233, 1'b1, 5'd4, 64'h0000000000000010};
        vecs[4] = '{32'h0030A2B3, 1'b1, 5'd5, 64'h0000000000000001};
        vecs[5] = '{32'h00700013, 1'b1, 5'd0, 64'h0000000000000000};
        vecs[6] = '{32'h0000006F, 1'b0, 5'd0, 64'h0000000000000000};
        vecs[7] = '{32'h0200C033, 1'b0, 5'd0, 64'h0000000000000000};
        for (int r = 0; r < 32; r++) ref_regs[r] = 64'd0;

        rst      = 1'b1;
        in_valid = 1'b0;
        in_instr = 32'd0;
        dbg_addr = 5'd0;
        @(negedge clk);
        checkOutput("reset_in_ready_low", in_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("reset_in_ready_high", in_ready, 1);
        checkOutput("reset_done_valid", done_valid, 0);
        checkOutput("reset_illegal", illegal, 0);
        checkOutput("reset_done_rd", done_rd, 0);
        checkOutput("reset_done_data", done_data, 0);
        checkOutput("reset_done_zero", done_zero, 0);
        checkOutput("reset_alu_a", alu_a, 0);
        checkOutput("reset_alu_b", alu_b, 0);
        checkOutput("reset_alu_funct3", alu_funct3, 0);
        checkOutput("reset_alu_funct7", alu_funct7, 0);
        check_all_regs("reset_regfile");
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].instr, 1'b1, vecs[i].legal, vecs[i].rd, vecs[i].data);
        end
        check_all_regs("after_table_regfile");

        // Reset landing in the EXEC cycle must cancel the write.
        in_valid = 1'b1;
        in_instr = 32'h00500093;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int r = 0; r < 32; r++) ref_regs[r] = 64'd0;
        #1;
        checkOutput("rst_exec_done_valid", done_valid, 0);
        checkOutput("rst_exec_in_ready", in_ready, 1);
        dbg_addr = 5'd1;
        #1;
        checkOutput("rst_exec_x1", dbg_data, 64'd0);
        @(negedge clk);
        checkOutput("rst_exec_done_valid_later", done_valid, 0);
        check_all_regs("rst_exec_regfile");

        for (int n = 0; n < 60; n++) begin
            applyStimulus(random_instr(), 1'b0, 1'b0, 5'd0, 64'd0);
        end
        check_all_regs("final_regfile");

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/alu_issue_unit.md
# alu_issue_unit

Sequencer that sits on the driving side of the RV64I integer ALU. It accepts one 32-bit OP or OP-IMM instruction at a time and decodes it. It reads source operands from an internal 32 x XLEN register file and drives a, b, funct3 and funct7 to the combinational ALU. It then captures the ALU result and writes it back to rd. This block is the operand producer and result consumer for the ALU, replacing testbench-driven operands in the integer datapath.

## Interface
- XLEN, 64, register and operand width; shift amounts use the low 6 bits.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  instruction offered.
- in_ready  output  1  unit can accept an instruction.
- in_instr  input  32  RV64I instruction word.
- alu_a  output  XLEN  ALU operand a (rs1 value).
- alu_b  output  XLEN  ALU operand b (rs2 value or sign-extended immediate).
- alu_funct3  output  3  ALU funct3.
- alu_funct7  output  7  ALU funct7.
- alu_result  input  XLEN  combinational ALU result.
- alu_zero  input  1  ALU zero flag; captured only as done_zero.
- done_valid  output  1  one-cycle pulse: write-back completed.
- done_rd  output  5  destination register of the completed instruction.
- done_data  output  XLEN  value written to done_rd (0 reported when rd = x0 is discarded).
- done_zero  output  1  alu_zero captured with the result.
- illegal  output  1  one-cycle pulse: instruction rejected.
- dbg_addr  input  5  register file debug read address.
- dbg_data  output  XLEN  combinational read of regfile[dbg_addr]; x0 reads 0.

## Operation
- FSM states: IDLE, DECODE, EXEC, WB.
  - IDLE: in_ready = 1. On in_valid, latch in_instr and go to DECODE.
  - DECODE: read rs1/rs2, check legality, then register alu_a, alu_b, alu_funct3 and alu_funct7. Legal goes to EXEC. Illegal sets illegal for one cycle and returns to IDLE.
  - EXEC: ALU settles. At the closing edge, write alu_result to regfile[rd] unless rd = 0, load done_rd/done_data/done_zero, and go to WB.
  - WB: done_valid = 1, then go to IDLE.
- Legal encodings:
  - opcode 0110011 (OP): funct7 0000000 with any funct3, or funct7 0100000 with funct3 000 or 101.
  - opcode 0010011 (OP-IMM): funct3 001 requires instr[31:26] = 000000. funct3 101 requires instr[31:26] = 000000 or 010000. Other funct3 values are always legal.
  - All other opcodes are illegal.
- Operand and funct generation:
  - OP: alu_b = rs2 value, alu_funct7 = instr[31:25].
  - OP-IMM: alu_b = sign-extend(instr[31:20]) to XLEN.
  - OP-IMM alu_funct7: {instr[31:26], 1'b0} for funct3 001/101. Forced to 0000000 for all other funct3, so ADDI never decodes as SUB.
  - alu_funct3 = instr[14:12].
- x0 reads 0 and is never written.
- The register file holds 32 entries and is cleared by rst.
- alu_* outputs hold their last values outside EXEC.

## Timing
- Accept edge E0: in_valid & in_ready.
  - The DECODE cycle follows E0.
  - Operands are valid on alu_* after E1.
  - Regfile write and done registers update at E2.
  - done_valid is high for the single cycle after E2.
  - in_ready returns high after E3.
- Throughput is one instruction per 4 cycles. There is no read-after-write hazard, because the next DECODE follows the previous write.
- Illegal instruction: illegal = 1 for the cycle after E1, with in_ready = 1 in that same cycle. There is no write and no done_valid.
- in_valid while not ready is ignored; the instruction is not latched.
- Reset values: in_ready = 0 during the rst cycle and 1 after it. done_valid = 0, illegal = 0. done_rd, done_data, done_zero and alu_* are all 0. All registers read 0.
- rst asserted in any state: the FSM goes to IDLE at that edge and no write occurs. An instruction in EXEC is lost.

## Test plan
- After reset, 0xFFF00093 (ADDI x1,x0,-1) -> done_valid pulse 3 cycles after accept with done_rd=1 and done_data=0xFFFFFFFFFFFFFFFF; dbg x1 matches.
- 0x4040D113 (SRAI x2,x1,4) -> x2=0xFFFFFFFFFFFFFFFF; alu_funct7=0100000.
- 0x03C0D193 (SRLI x3,x1,60) -> x3=0xF. Then 0x40118233 (SUB x4,x3,x1) -> x4=0x10.
- 0x0030A2B3 (SLT x5,x1,x3) -> x5=1. 0x00700013 (ADDI x0,x0,7) -> done_rd=0 and dbg x0=0.
- 0x0000006F (JAL) -> illegal pulse 2 cycles after accept, no done_valid, all registers unchanged. 0x0200C033 (funct7=0000001) -> illegal.
- rst asserted in the EXEC cycle of 0x00500093 -> x1 not written, done_valid stays 0, in_ready=1 the cycle after rst deasserts.
